lc3b_ctrl_pipe: RTL and testbench



---
 rtl/lc3b_ctrl_pipe.sv | 266 ++++++++++++++++++++++++++
 tb/tb_lc3b_ctrl_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_ctrl_pipe.sv
// lc3b_ctrl_pipe
// Decodes the ID-stage LC-3b instruction into a control word. The word is
// carried through EX, a MEM_LAT-deep MEM section and WB. Each stage has its
// own valid bit. LDI/STI are optionally expanded into two EX micro-ops.
//
// Parameters:
//   MEM_LAT      number of MEM control registers between mem_ctrl and wb_ctrl (1..4)
// Configuration macro:
//   CTRL_INDIRECT_EN  when defined, LDI/STI are sequenced as two micro-ops.
//                     When undefined, they decode as unsupported opcodes,
//                     ex_ind2 is tied 0 and id_ready is tied 1.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   instr_valid, instruction      ID-stage instruction and its valid bit
//   stall                         holds every register and the FSM
//   flush                         squashes the ID instruction and the EX stage
//   id_ready                      ID may advance this cycle
//   ex_ctrl/mem_ctrl/wb_ctrl      stage control words
//   ex_valid/mem_valid/wb_valid   stage holds a live micro-op
//   ex_ind2                       EX holds the second phase of an indirect op

package lc3b_ctrl_pkg;
  typedef enum logic [2:0] {
    alu_add  = 3'd0,
    alu_and  = 3'd1,
    alu_not  = 3'd2,
    alu_pass = 3'd3,
    alu_sll  = 3'd4,
    alu_srl  = 3'd5,
    alu_sra  = 3'd6
  } lc3b_aluop;

  typedef struct packed {
    lc3b_aluop  aluop;
    logic [2:0] alumux_sela;
    logic [2:0] alumux_selb;
    logic       sr1mux_sel;
    logic [2:0] regfilemux_sel;
    logic [2:0] wdatamux_sel;
    logic       load_regfile;
    logic       load_cc;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
  } lc3b_control_word;
endpackage

module lc3b_ctrl_pipe
  import lc3b_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [15:0]      instruction,
  input  logic             stall,
  input  logic             flush,
  output logic             id_ready,
  output lc3b_control_word ex_ctrl,
  output lc3b_control_word mem_ctrl,
  output lc3b_control_word wb_ctrl,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic             ex_ind2
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_SHF = 4'b1101;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [3:0]       opcode;
  lc3b_control_word op_word;
  lc3b_control_word ex_next;
  logic             ex_next_valid;

  lc3b_control_word mem_q [MEM_LAT];
  logic [MEM_LAT-1:0] mem_v;

  // Register, offset and immediate fields are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instruction[11:6], instruction[3:1]};

  assign opcode = instruction[15:12];

  // Single-instruction decode. Unsupported opcodes (and LDI/STI, which the
  // sequencer overrides when enabled) give an all-zero word.
  always_comb begin
    op_word = '0;
    op_word.aluop = alu_pass;
    op_word.mem_byte_enable = 2'b11;
    case (opcode)
      OP_ADD, OP_AND: begin
        op_word.aluop = (opcode == OP_ADD) ? alu_add : alu_and;
        op_word.alumux_selb = instruction[5] ? 3'b010 : 3'b000;
        op_word.load_regfile = 1'b1;
        op_word.load_cc = 1'b1;
      end
      OP_NOT: begin
        op_word.aluop = alu_not;
        op_word.load_regfile = 1'b1;
        op_word.load_cc = 1'b1;
      end
      OP_LDR, OP_LDB: begin
        op_word.aluop = alu_add;
        op_word.alumux_selb = (opcode == OP_LDB) ? 3'b110 : 3'b001;
        op_word.mem_read = 1'b1;
        op_word.regfilemux_sel = 3'b001;
        op_word.load_regfile = 1'b1;
        op_word.load_cc = 1'b1;
        if (opcode == OP_LDB) op_word.mem_byte_enable = instruction[0] ? 2'b10 : 2'b01;
      end
      OP_STR, OP_STB: begin
        op_word.aluop = alu_add;
        op_word.alumux_selb = (opcode == OP_STB) ? 3'b110 : 3'b001;
        op_word.sr1mux_sel = 1'b1;
        op_word.mem_write = 1'b1;
        op_word.wdatamux_sel = 3'b001;
        if (opcode == OP_STB) op_word.mem_byte_enable = instruction[0] ? 2'b10 : 2'b01;
      end
      OP_LEA: begin
        op_word.aluop = alu_add;
        op_word.alumux_sela = 3'b100;
        op_word.alumux_selb = 3'b100;
        op_word.load_regfile = 1'b1;
      end
      OP_SHF: begin
        op_word.alumux_selb = 3'b101;
        op_word.load_regfile = 1'b1;
        op_word.load_cc = 1'b1;
        if (!instruction[4])      op_word.aluop = alu_sll;
        else if (!instruction[5]) op_word.aluop = alu_srl;
        else                      op_word.aluop = alu_sra;
      end
      default: op_word = '0;
    endcase
  end

`ifdef CTRL_INDIRECT_EN
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  typedef enum logic {IDLE, IND2} ind_state_t;

  ind_state_t       state, state_next;
  logic             ind_store, ind_store_next;
  logic             ex_next_ind2;
  lc3b_control_word phase1_word, phase2_word;

  // Phase 1 fetches the pointer; phase 2 uses the loaded MDR as the address.
  // Only load-vs-store is remembered, since that is all phase 2 depends on.
  always_comb begin
    phase1_word = '0;
    phase1_word.aluop = alu_add;
    phase1_word.alumux_selb = 3'b001;
    phase1_word.mem_read = 1'b1;
    phase1_word.mem_byte_enable = 2'b11;

    phase2_word = '0;
    phase2_word.aluop = alu_pass;
    phase2_word.alumux_sela = 3'b011;
    phase2_word.mem_byte_enable = 2'b11;
    if (ind_store) begin
      phase2_word.mem_write = 1'b1;
      phase2_word.sr1mux_sel = 1'b1;
      phase2_word.wdatamux_sel = 3'b001;
    end else begin
      phase2_word.mem_read = 1'b1;
      phase2_word.regfilemux_sel = 3'b001;
      phase2_word.load_regfile = 1'b1;
      phase2_word.load_cc = 1'b1;
    end
  end

  // Next EX contents and FSM step. Flush drops any pending phase 2; in IND2
  // the ID instruction is ignored because it is the one after the LDI/STI.
  always_comb begin
    ex_next = '0;
    ex_next_valid = 1'b0;
    ex_next_ind2 = 1'b0;
    state_next = state;
    ind_store_next = ind_store;
    if (flush) begin
      state_next = IDLE;
    end else if (state == IND2) begin
      ex_next = phase2_word;
      ex_next_valid = 1'b1;
      ex_next_ind2 = 1'b1;
      state_next = IDLE;
    end else if (instr_valid) begin
      if (opcode == OP_LDI || opcode == OP_STI) begin
        ex_next = phase1_word;
        ex_next_valid = 1'b1;
        state_next = IND2;
        ind_store_next = (opcode == OP_STI);
      end else begin
        ex_next = op_word;
        ex_next_valid = 1'b1;
      end
    end
  end

  // FSM state, the latched load/store flag and the EX phase-2 marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ind_store <= 1'b0;
      ex_ind2 <= 1'b0;
    end else if (!stall) begin
      state <= state_next;
      ind_store <= ind_store_next;
      ex_ind2 <= ex_next_ind2;
    end
  end

  assign id_ready = (state == IDLE);
`else
  // Without indirect sequencing, EX simply takes the decoded word.
  always_comb begin
    ex_next = '0;
    ex_next_valid = 1'b0;
    if (!flush && instr_valid) begin
      ex_next = op_word;
      ex_next_valid = 1'b1;
    end
  end

  assign ex_ind2 = 1'b0;
  assign id_ready = 1'b1;
`endif

  // Stage registers: EX, the MEM shift chain and WB all advance together
  // and hold as a unit under stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_ctrl <= '0;
      ex_valid <= 1'b0;
      for (int i = 0; i < MEM_LAT; i++) mem_q[i] <= '0;
      mem_v <= '0;
      wb_ctrl <= '0;
      wb_valid <= 1'b0;
    end else if (!stall) begin
      ex_ctrl <= ex_next;
      ex_valid <= ex_next_valid;
      mem_q[0] <= ex_ctrl;
      mem_v[0] <= ex_valid;
      for (int i = 1; i < MEM_LAT; i++) begin
        mem_q[i] <= mem_q[i-1];
        mem_v[i] <= mem_v[i-1];
      end
      wb_ctrl <= mem_q[MEM_LAT-1];
      wb_valid <= mem_v[MEM_LAT-1];
    end
  end

  assign mem_ctrl = mem_q[0];
  assign mem_valid = mem_v[0];

endmodule

// File: tb/tb_lc3b_ctrl_pipe.sv
// tb_lc3b_ctrl_pipe
// Self-checking bench for lc3b_ctrl_pipe with MEM_LAT = 2. Expected stage
// contents come from hand-written control words; a queue holds the expected
// EX entries so MEM and WB are checked as those entries age.
// Expectations for LDI/STI follow whether CTRL_INDIRECT_EN is defined.

module tb_lc3b_ctrl_pipe;
  import lc3b_ctrl_pkg::*;

  localparam int MEM_LAT = 2;
  localparam int DEPTH = 2 + MEM_LAT;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             instr_valid = 1'b0;
  logic [15:0]      instruction = 16'h0000;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic             id_ready;
  lc3b_control_word ex_ctrl, mem_ctrl, wb_ctrl;
  logic             ex_valid, mem_valid, wb_valid, ex_ind2;

  lc3b_ctrl_pipe #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction),
    .stall(stall), .flush(flush), .id_ready(id_ready),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid), .ex_ind2(ex_ind2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    lc3b_control_word w;
    logic             v;
    logic             i2;
  } stage_t;

  typedef struct {
    logic             iv;
    logic [15:0]      ins;
    lc3b_control_word w;
    logic             v;
  } vec_t;

  stage_t pipe_q[$];
  logic   exp_ready;
  int     n_checks = 0;
  int     n_pass = 0;
  vec_t   vecs[16];

  function automatic lc3b_control_word mk(
    input lc3b_aluop op, input logic [2:0] sa, input logic [2:0] sb, input logic sr1,
    input logic [2:0] rf, input logic [2:0] wd, input logic lrf, input logic lcc,
    input logic rd, input logic wr, input logic [1:0] be);
    lc3b_control_word w;
    w.aluop = op; w.alumux_sela = sa; w.alumux_selb = sb; w.sr1mux_sel = sr1;
    w.regfilemux_sel = rf; w.wdatamux_sel = wd; w.load_regfile = lrf; w.load_cc = lcc;
    w.mem_read = rd; w.mem_write = wr; w.mem_byte_enable = be;
    return w;
  endfunction

  function automatic stage_t stg(input lc3b_control_word w, input logic v, input logic i2);
    stage_t s;
    s.w = w; s.v = v; s.i2 = i2;
    return s;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic check_output();
    cmp("ex_ctrl",   32'(ex_ctrl),   32'(pipe_q[0].w));
    cmp("ex_valid",  32'(ex_valid),  32'(pipe_q[0].v));
    cmp("ex_ind2",   32'(ex_ind2),   32'(pipe_q[0].i2));
    cmp("mem_ctrl",  32'(mem_ctrl),  32'(pipe_q[1].w));
    cmp("mem_valid", 32'(mem_valid), 32'(pipe_q[1].v));
    cmp("wb_ctrl",   32'(wb_ctrl),   32'(pipe_q[1+MEM_LAT].w));
    cmp("wb_valid",  32'(wb_valid),  32'(pipe_q[1+MEM_LAT].v));
    cmp("id_ready",  32'(id_ready),  32'(exp_ready));
  endtask

  // One clock of stimulus. When not stalled, exp becomes the new EX entry and
  // rdy the new id_ready; when stalled both are ignored and nothing may move.
  task automatic apply_stimulus(input logic iv, input logic [15:0] ins, input logic st,
                                input logic fl, input stage_t exp, input logic rdy);
    @(negedge clk);
    reset = 1'b0; instr_valid = iv; instruction = ins; stall = st; flush = fl;
    @(posedge clk);
    #1;
    if (!st) begin
      pipe_q.push_front(exp);
      void'(pipe_q.pop_back());
      exp_ready = rdy;
    end
    check_output();
  endtask

  task automatic apply_reset(input logic st, input logic fl);
    @(negedge clk);
    reset = 1'b1; instr_valid = 1'b1; instruction = 16'h12A3; stall = st; flush = fl;
    @(posedge clk);
    #1;
    pipe_q.delete();
    for (int i = 0; i < DEPTH; i++) pipe_q.push_back('0);
    exp_ready = 1'b1;
    check_output();
  endtask

  initial begin
    lc3b_control_word w_add_i, w_and_i, w_add_r, w_not, w_ldr, w_str, w_p1, w_p2l, w_p2s;
    stage_t e_ldi_a, e_ldi_b, e_sti_a;
    logic   r_ind;

    w_add_i = mk(alu_add, 3'd0, 3'b010, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
    w_add_r = mk(alu_add, 3'd0, 3'b000, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
    w_and_i = mk(alu_and, 3'd0, 3'b010, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
    w_not   = mk(alu_not, 3'd0, 3'b000, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11);
    w_ldr   = mk(alu_add, 3'd0, 3'b001, 1'b0, 3'b001, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
    w_str   = mk(alu_add, 3'd0, 3'b001, 1'b1, 3'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    w_p1    = mk(alu_add, 3'd0, 3'b001, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11);
    w_p2l   = mk(alu_pass, 3'b011, 3'd0, 1'b0, 3'b001, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
    w_p2s   = mk(alu_pass, 3'b011, 3'd0, 1'b1, 3'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);

    vecs[0]  = '{1'b1, 16'h12A3, w_add_i, 1'b1};
    vecs[1]  = '{1'b1, 16'h1042, w_add_r, 1'b1};
    vecs[2]  = '{1'b1, 16'h5261, w_and_i, 1'b1};
    vecs[3]  = '{1'b1, 16'h5042, mk(alu_and, 3'd0, 3'b000, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11), 1'b1};
    vecs[4]  = '{1'b1, 16'h927F, w_not, 1'b1};
    vecs[5]  = '{1'b1, 16'h6283, w_ldr, 1'b1};
    vecs[6]  = '{1'b1, 16'h7283, w_str, 1'b1};
    vecs[7]  = '{1'b1, 16'h2281, mk(alu_add, 3'd0, 3'b110, 1'b0, 3'b001, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10), 1'b1};
    vecs[8]  = '{1'b1, 16'h3280, mk(alu_add, 3'd0, 3'b110, 1'b1, 3'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01), 1'b1};
    vecs[9]  = '{1'b1, 16'hE205, mk(alu_add, 3'b100, 3'b100, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11), 1'b1};
    vecs[10] = '{1'b1, 16'hD201, mk(alu_sll, 3'd0, 3'b101, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11), 1'b1};
    vecs[11] = '{1'b1, 16'hD211, mk(alu_srl, 3'd0, 3'b101, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11), 1'b1};
    vecs[12] = '{1'b1, 16'hD231, mk(alu_sra, 3'd0, 3'b101, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11), 1'b1};
    vecs[13] = '{1'b1, 16'h0E01, '0, 1'b1};
    vecs[14] = '{1'b1, 16'hF025, '0, 1'b1};
    vecs[15] = '{1'b0, 16'h12A3, '0, 1'b0};

`ifdef CTRL_INDIRECT_EN
    e_ldi_a = stg(w_p1, 1'b1, 1'b0);
    e_ldi_b = stg(w_p2l, 1'b1, 1'b1);
    e_sti_a = stg(w_p1, 1'b1, 1'b0);
    r_ind = 1'b0;
`else
    e_ldi_a = stg('0, 1'b1, 1'b0);
    e_ldi_b = stg(w_add_i, 1'b1, 1'b0);
    e_sti_a = stg('0, 1'b1, 1'b0);
    r_ind = 1'b1;
`endif

    // Reset, held with stall and flush also high.
    apply_reset(1'b1, 1'b1);
    apply_reset(1'b0, 1'b0);

    // Table-driven decode; the trailing bubbles let the last words reach WB.
    for (int i = 0; i < 16; i++)
      apply_stimulus(vecs[i].iv, vecs[i].ins, 1'b0, 1'b0, stg(vecs[i].w, vecs[i].v, 1'b0), 1'b1);
    for (int i = 0; i < DEPTH; i++)
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, '0, 1'b1);

    // LDI: phase 1, then phase 2 while the next instruction waits in ID.
    apply_stimulus(1'b1, 16'hA245, 1'b0, 1'b0, e_ldi_a, r_ind);
    apply_stimulus(1'b1, 16'h12A3, 1'b0, 1'b0, e_ldi_b, 1'b1);
    apply_stimulus(1'b1, 16'h12A3, 1'b0, 1'b0, stg(w_add_i, 1'b1, 1'b0), 1'b1);

    // STI, then flush in IND2 drops phase 2.
    apply_stimulus(1'b1, 16'hB245, 1'b0, 1'b0, e_sti_a, r_ind);
    apply_stimulus(1'b1, 16'h12A3, 1'b0, 1'b1, '0, 1'b1);
    apply_stimulus(1'b1, 16'h6283, 1'b0, 1'b0, stg(w_ldr, 1'b1, 1'b0), 1'b1);

    // STI completing normally.
    apply_stimulus(1'b1, 16'hB245, 1'b0, 1'b0, e_sti_a, r_ind);
`ifdef CTRL_INDIRECT_EN
    apply_stimulus(1'b1, 16'h927F, 1'b0, 1'b0, stg(w_p2s, 1'b1, 1'b1), 1'b1);
`else
    apply_stimulus(1'b1, 16'h927F, 1'b0, 1'b0, stg(w_not, 1'b1, 1'b0), 1'b1);
`endif

    // Three-cycle stall right after an LDI, flush pulsed mid-stall.
    apply_stimulus(1'b1, 16'h927F, 1'b0, 1'b0, stg(w_not, 1'b1, 1'b0), 1'b1);
    apply_stimulus(1'b1, 16'hA245, 1'b0, 1'b0, e_ldi_a, r_ind);
    apply_stimulus(1'b1, 16'h12A3, 1'b1, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 16'h12A3, 1'b1, 1'b1, '0, 1'b0);
    apply_stimulus(1'b0, 16'h12A3, 1'b1, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 16'h12A3, 1'b0, 1'b0, e_ldi_b, 1'b1);
    apply_stimulus(1'b1, 16'h5261, 1'b0, 1'b0, stg(w_and_i, 1'b1, 1'b0), 1'b1);

    // Flush in IDLE squashes a valid instruction.
    apply_stimulus(1'b1, 16'h6283, 1'b0, 1'b1, '0, 1'b1);

    // Random mix of table entries with random stall and flush.
    for (int i = 0; i < 40; i++) begin
      int   idx;
      logic st, fl;
      idx = int'($urandom_range(0, 15));
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      apply_stimulus(vecs[idx].iv, vecs[idx].ins, st, fl,
                     fl ? stage_t'('0) : stg(vecs[idx].w, vecs[idx].v, 1'b0), 1'b1);
    end

    // Reset mid-stream wins over stall and flush, then restart.
    apply_stimulus(1'b1, 16'h7283, 1'b0, 1'b0, stg(w_str, 1'b1, 1'b0), 1'b1);
    apply_reset(1'b1, 1'b1);
    apply_stimulus(1'b1, 16'h12A3, 1'b0, 1'b0, stg(w_add_i, 1'b1, 1'b0), 1'b1);
    apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
